// File: rtl/cve2_csr_rmw_ctrl.sv
// cve2_csr_rmw_ctrl
// Read-modify-write sequencer sitting in front of a single CSR storage
// primitive. It accepts one READ/WRITE/SET/CLEAR access per request
// handshake. It samples the current CSR value and the shadow-error flag, then
// issues at most one single-cycle write pulse carrying the masked new value.
// The old value and an error flag are returned on a valid/ready response
// channel. A sticky integrity alert records any shadow mismatch that is seen.
//
// Ports
//   clk_i, rst_ni          clock (rising edge), synchronous active-low reset
//   req_valid_i/ready_o    request handshake; req_op_i selects the access,
//                          req_wdata_i is its operand
//   rsp_valid_o/ready_i    response handshake; rsp_rdata_o is the CSR value
//                          before the access, rsp_err_o flags a failure
//   csr_rd_data_i          current CSR value from the storage primitive
//   csr_rd_error_i         shadow mismatch flag from the storage primitive
//   csr_wr_data_o          write data to the storage primitive
//   csr_wr_en_o            write enable to the storage primitive (1 cycle)
//   lock_i                 rejects every modifying access while high
//   alert_o, alert_clr_i   sticky integrity alert and its clear
module cve2_csr_rmw_ctrl #(
  parameter int unsigned      Width       = 32,
  parameter logic [Width-1:0] WriteMask   = {Width{1'b1}},
  parameter bit               ShadowCheck = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [Width-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [Width-1:0] rsp_rdata_o,
  output logic             rsp_err_o,
  input  logic [Width-1:0] csr_rd_data_i,
  input  logic             csr_rd_error_i,
  output logic [Width-1:0] csr_wr_data_o,
  output logic             csr_wr_en_o,
  input  logic             lock_i,
  output logic             alert_o,
  input  logic             alert_clr_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [Width-1:0] wdata_q, wdata_d;
  logic [Width-1:0] old_q, old_d;
  logic             rsp_err_q, rsp_err_d;
  logic [Width-1:0] wr_data_q, wr_data_d;
  logic             alert_q, alert_d;

  logic             rd_err;
  logic             modifying;
  logic [Width-1:0] raw_val;
  logic [Width-1:0] new_val;

  // With shadow checking disabled the primitive's error flag is ignored.
  assign rd_err = ShadowCheck ? csr_rd_error_i : 1'b0;

  // SET/CLEAR with a zero operand cannot change the CSR and count as reads.
  assign modifying = (op_q == OP_WRITE) |
                     (((op_q == OP_SET) | (op_q == OP_CLEAR)) & (|wdata_q));

  // The new value is built from the live CSR data during CHECK and
  // registered, so the write pulse in WRITE carries a flopped value.
  always_comb begin
    raw_val = wdata_q;
    case (op_q)
      OP_SET:   raw_val = csr_rd_data_i | wdata_q;
      OP_CLEAR: raw_val = csr_rd_data_i & ~wdata_q;
      default:  raw_val = wdata_q;
    endcase
    new_val = (csr_rd_data_i & ~WriteMask) | (raw_val & WriteMask);
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wdata_d   = wdata_q;
    old_d     = old_q;
    rsp_err_d = rsp_err_q;
    wr_data_d = wr_data_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          op_d    = req_op_i;
          wdata_d = req_wdata_i;
          state_d = CHECK;
        end
      end
      CHECK: begin
        old_d = csr_rd_data_i;
        if (rd_err) begin
          rsp_err_d = 1'b1;
          state_d   = RESP;
        end else if (modifying && lock_i) begin
          rsp_err_d = 1'b1;
          state_d   = RESP;
        end else if (modifying) begin
          rsp_err_d = 1'b0;
          wr_data_d = new_val;
          state_d   = WRITE;
        end else begin
          rsp_err_d = 1'b0;
          state_d   = RESP;
        end
      end
      WRITE: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Alert runs independently of the FSM; a new error beats a clear.
  always_comb begin
    alert_d = alert_q;
    if (alert_clr_i) begin
      alert_d = 1'b0;
    end
    if ((state_q == CHECK) && rd_err) begin
      alert_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      op_q      <= OP_READ;
      wdata_q   <= '0;
      old_q     <= '0;
      rsp_err_q <= 1'b0;
      wr_data_q <= '0;
      alert_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wdata_q   <= wdata_d;
      old_q     <= old_d;
      rsp_err_q <= rsp_err_d;
      wr_data_q <= wr_data_d;
      alert_q   <= alert_d;
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_rdata_o   = (state_q == RESP) ? old_q : '0;
  assign rsp_err_o     = (state_q == RESP) & rsp_err_q;
  assign csr_wr_en_o   = (state_q == WRITE);
  assign csr_wr_data_o = wr_data_q;
  assign alert_o       = alert_q;

endmodule

// File: tb/tb_cve2_csr_rmw_ctrl.sv
module tb_cve2_csr_rmw_ctrl;

  localparam logic [31:0] MASK = 32'h0000_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] csr_mem;
  logic        csr_rd_error;
  logic [31:0] csr_wr_data;
  logic        csr_wr_en;
  logic        lock;
  logic        alert;
  logic        alert_clr;

  cve2_csr_rmw_ctrl #(.Width(32), .WriteMask(MASK), .ShadowCheck(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .csr_rd_data_i(csr_mem), .csr_rd_error_i(csr_rd_error),
    .csr_wr_data_o(csr_wr_data), .csr_wr_en_o(csr_wr_en),
    .lock_i(lock), .alert_o(alert), .alert_clr_i(alert_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          hs;
  } rsp_t;

  rsp_t        rq[$];
  logic [31:0] wq[$];
  int          tests = 0;
  int          fails = 0;
  int          cycle = 0;
  bit          hold = 1'b0;
  bit          in_check = 1'b0;
  bit          prev_valid = 1'b0;
  logic        exp_alert = 1'b0;
  logic        ext_load = 1'b0;
  logic [31:0] ext_val = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  // CSR storage primitive: takes DUT writes, or a preset from the stimulus.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (csr_wr_en) csr_mem <= csr_wr_data;
    else if (ext_load) csr_mem <= ext_val;
  end

  // Alert reference: set by an error seen in CHECK, cleared by clear, set wins.
  always @(posedge clk) begin
    if (!rst_n) exp_alert <= 1'b0;
    else if (in_check && csr_rd_error) exp_alert <= 1'b1;
    else if (alert_clr) exp_alert <= 1'b0;
  end

  // Response backpressure, changed just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    rsp_ready = hold ? 1'b0 : ($urandom_range(0, 2) != 0);
  end

  // Monitor: compares DUT outputs against the scoreboard queues.
  always @(negedge clk) begin
    chk("alert", {31'b0, alert}, {31'b0, exp_alert});
    if (csr_wr_en) begin
      if (wq.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
      else chk("wr_data", csr_wr_data, wq.pop_front());
    end
    if (rsp_valid) begin
      chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
      if (rq.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        if (!prev_valid) chk("latency", cycle - rq[0].hs, rq[0].lat);
        chk("rsp_rdata", rsp_rdata, rq[0].rdata);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, rq[0].err});
        if (rsp_ready) begin
          chk("writes_before_rsp", wq.size(), 32'd0);
          $display("[TB] rsp rdata=%h err=%0d lat=%0d", rsp_rdata, rsp_err, rq[0].lat);
          void'(rq.pop_front());
        end
      end
    end
    prev_valid = rsp_valid && !rsp_ready;
  end

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // One access: optional CSR preset, then handshake, then CHECK-cycle inputs.
  task automatic do_txn(input logic [1:0] op, input logic [31:0] wd, input bit e,
                        input bit lk, input bit c, input bit ld, input logic [31:0] ldv);
    logic [31:0] old, raw, nv;
    bit   mod;
    rsp_t r;
    wait_idle();
    if (ld) begin
      ext_val  = ldv;
      ext_load = 1'b1;
      @(negedge clk);
      ext_load = 1'b0;
    end
    old = csr_mem;
    mod = (op == 2'b01) || ((op[1] == 1'b1) && (wd != 0));
    case (op)
      2'b10:   raw = old | wd;
      2'b11:   raw = old & ~wd;
      default: raw = wd;
    endcase
    nv      = (old & ~MASK) | (raw & MASK);
    r.rdata = old;
    r.hs    = cycle;
    if (e)              begin r.err = 1'b1; r.lat = 2; end
    else if (mod && lk) begin r.err = 1'b1; r.lat = 2; end
    else if (mod)       begin r.err = 1'b0; r.lat = 3; wq.push_back(nv); end
    else                begin r.err = 1'b0; r.lat = 2; end
    rq.push_back(r);
    $display("[TB] req op=%0d wdata=%h csr=%h err_inj=%0d lock=%0d", op, wd, old, e, lk);
    req_valid = 1'b1;
    req_op    = op;
    req_wdata = wd;
    @(negedge clk);
    req_valid    = 1'b0;
    req_op       = 2'($urandom);
    req_wdata    = $urandom;
    csr_rd_error = e;
    lock         = lk;
    alert_clr    = c;
    in_check     = 1'b1;
    @(negedge clk);
    in_check     = 1'b0;
    csr_rd_error = 1'($urandom);
    lock         = 1'($urandom);
    alert_clr    = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_wdata = '0;
    csr_rd_error = 1'b0; lock = 1'b0; alert_clr = 1'b0; csr_mem = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_wr_en", {31'b0, csr_wr_en}, 32'd0);
    chk("rst_wr_data", csr_wr_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed accesses
    do_txn(2'b00, 32'h0, 0, 0, 0, 1, 32'h0000_00F0);
    do_txn(2'b01, 32'h1234_5678, 0, 0, 0, 1, 32'hAAAA_0000);
    do_txn(2'b10, 32'h0000_00F0, 0, 0, 0, 1, 32'h0000_000F);
    do_txn(2'b11, 32'h0000_0003, 0, 0, 0, 0, 32'h0);
    do_txn(2'b10, 32'h0, 0, 0, 0, 0, 32'h0);
    do_txn(2'b01, 32'h0000_1111, 1, 0, 0, 0, 32'h0);
    do_txn(2'b00, 32'h0, 1, 0, 1, 0, 32'h0);
    do_txn(2'b00, 32'h0, 0, 0, 1, 0, 32'h0);
    do_txn(2'b01, 32'h0000_0005, 0, 1, 0, 0, 32'h0);
    do_txn(2'b00, 32'h0, 0, 1, 0, 0, 32'h0);

    // Backpressure: response held for several cycles
    wait_idle();
    hold = 1'b1;
    do_txn(2'b00, 32'h0, 0, 0, 0, 1, 32'h5A5A_A5A5);
    repeat (6) @(negedge clk);
    chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
    hold = 1'b0;

    // Reset while in WRITE: the pulse in flight is seen, nothing afterwards
    wait_idle();
    wq.push_back((csr_mem & ~MASK) | (32'h0000_BEEF & MASK));
    $display("[TB] req op=1 wdata=0000beef (reset during WRITE)");
    req_valid = 1'b1; req_op = 2'b01; req_wdata = 32'h0000_BEEF;
    @(negedge clk);
    req_valid = 1'b0; csr_rd_error = 1'b0; lock = 1'b0; alert_clr = 1'b0;
    @(negedge clk);
    chk("pre_reset_wr_en", {31'b0, csr_wr_en}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("post_reset_wr_en", {31'b0, csr_wr_en}, 32'd0);
    chk("post_reset_idle", {31'b0, req_ready}, 32'd1);
    chk("post_reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_no_rsp", {31'b0, rsp_valid}, 32'd0);

    // Randomized accesses
    for (int i = 0; i < 150; i++) begin
      do_txn(2'($urandom), ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom,
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), $urandom);
    end

    wait_idle();
    repeat (2) @(negedge clk);
    chk("rsp_queue_empty", rq.size(), 32'd0);
    chk("wr_queue_empty", wq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
